conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_sequencer: walks a FILTER_SIZE window over an image, one row band at a |
// | time, requesting bands from an external loader.          Revision: 1.0      |
// +----------------------------------------------------------------------------+
module conv_sequencer #(
   parameter int IMAGE_WIDTH  = 9,
   parameter int IMAGE_HEIGHT = 9,
   parameter int FILTER_SIZE  = 3,
   parameter int LOAD_TIMEOUT = 15
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   output logic                          new_buffer,
   input  logic                          loaded,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [$clog2(IMAGE_WIDTH):0]  win_col,
   output logic [$clog2(IMAGE_HEIGHT):0] win_row,
   output logic                          win_last,
   output logic                          busy,
   output logic                          done,
   output logic                          aborted,
   output logic                          error
);
   localparam int CW = $clog2(IMAGE_WIDTH) + 1;
   localparam int RW = $clog2(IMAGE_HEIGHT) + 1;
   localparam int NB = IMAGE_HEIGHT - FILTER_SIZE + 1;
   localparam int BW = $clog2(NB + 1);
   localparam int TW = $clog2(LOAD_TIMEOUT + 1);

   localparam logic [CW-1:0] c_COL_MAX  = CW'(IMAGE_WIDTH - FILTER_SIZE);
   localparam logic [RW-1:0] c_ROW_MAX  = RW'(IMAGE_HEIGHT - FILTER_SIZE);
   localparam logic [BW-1:0] c_NB       = BW'(NB);
   localparam logic [TW-1:0] c_TMO_LAST = TW'(LOAD_TIMEOUT - 1);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_LOAD  = 3'd1;
   localparam logic [2:0] c_WAIT  = 3'd2;
   localparam logic [2:0] c_SCAN  = 3'd3;
   localparam logic [2:0] c_FLUSH = 3'd4;
   localparam logic [2:0] c_ERR   = 3'd5;

   logic [2:0]    r_state, w_state_nx;
   logic [BW-1:0] r_band, w_band_nx;
   logic [BW-1:0] r_flush, w_flush_nx;
   logic [TW-1:0] r_tmo, w_tmo_nx;
   logic [CW-1:0] w_col_nx;
   logic [RW-1:0] w_row_nx;
   logic          w_nb_nx, w_valid_nx, w_last_nx, w_busy_nx;
   logic          w_done_nx, w_aborted_nx, w_error_nx;
   logic          w_xfer, w_col_end, w_row_end;

   assign w_xfer    = win_valid && win_ready;
   assign w_col_end = (win_col == c_COL_MAX);
   assign w_row_end = (win_row == c_ROW_MAX);

   // State and every output are registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_IDLE;
         r_band     <= '0;
         r_flush    <= '0;
         r_tmo      <= '0;
         new_buffer <= 1'b0;
         win_valid  <= 1'b0;
         win_col    <= '0;
         win_row    <= '0;
         win_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         error      <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_band     <= w_band_nx;
         r_flush    <= w_flush_nx;
         r_tmo      <= w_tmo_nx;
         new_buffer <= w_nb_nx;
         win_valid  <= w_valid_nx;
         win_col    <= w_col_nx;
         win_row    <= w_row_nx;
         win_last   <= w_last_nx;
         busy       <= w_busy_nx;
         done       <= w_done_nx;
         aborted    <= w_aborted_nx;
         error      <= w_error_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         c_IDLE, c_ERR: begin
            if (start) w_state_nx = c_LOAD;
         end
         c_LOAD: w_state_nx = abort ? c_FLUSH : c_WAIT;
         c_WAIT: begin
            if (abort)                     w_state_nx = c_FLUSH;
            else if (loaded)               w_state_nx = c_SCAN;
            else if (r_tmo == c_TMO_LAST)  w_state_nx = c_ERR;
         end
         c_SCAN: begin
            if (abort)                       w_state_nx = c_FLUSH;
            else if (w_xfer && w_col_end)    w_state_nx = w_row_end ? c_IDLE : c_LOAD;
         end
         c_FLUSH: begin
            if (r_flush == '0) w_state_nx = c_IDLE;
         end
         default: w_state_nx = c_IDLE;
      endcase
   end

   always_comb begin
      w_band_nx    = r_band;
      w_flush_nx   = r_flush;
      w_tmo_nx     = '0;
      w_nb_nx      = 1'b0;
      w_valid_nx   = win_valid;
      w_col_nx     = win_col;
      w_row_nx     = win_row;
      w_done_nx    = 1'b0;
      w_aborted_nx = 1'b0;
      w_error_nx   = error;
      case (r_state)
         c_IDLE, c_ERR: begin
            if (start) begin
               w_error_nx = 1'b0;
               w_row_nx   = '0;
               w_col_nx   = '0;
               w_band_nx  = '0;
               w_valid_nx = 1'b0;
            end
         end
         c_LOAD, c_WAIT, c_SCAN: begin
            if (abort) begin
               // Replay enough band requests to bring the loader pointer back to 0.
               w_valid_nx = 1'b0;
               w_flush_nx = (r_band == '0) ? '0 : c_NB - r_band;
            end else if (r_state == c_LOAD) begin
               w_nb_nx   = 1'b1;
               w_band_nx = r_band + BW'(1);
            end else if (r_state == c_WAIT) begin
               if (loaded) begin
                  w_valid_nx = 1'b1;
                  w_col_nx   = '0;
               end else if (r_tmo == c_TMO_LAST) begin
                  w_error_nx = 1'b1;
               end else begin
                  w_tmo_nx = r_tmo + TW'(1);
               end
            end else if (w_xfer) begin
               if (!w_col_end) begin
                  w_col_nx = win_col + CW'(1);
               end else begin
                  w_valid_nx = 1'b0;
                  if (!w_row_end) w_row_nx  = win_row + RW'(1);
                  else            w_done_nx = 1'b1;
               end
            end
         end
         c_FLUSH: begin
            if (r_flush != '0) begin
               w_nb_nx    = 1'b1;
               w_flush_nx = r_flush - BW'(1);
            end else begin
               w_aborted_nx = 1'b1;
            end
         end
         default: ;
      endcase
      w_last_nx = (w_col_nx == c_COL_MAX) && (w_row_nx == c_ROW_MAX);
      w_busy_nx = (w_state_nx == c_LOAD) || (w_state_nx == c_WAIT) ||
                  (w_state_nx == c_SCAN) || (w_state_nx == c_FLUSH);
   end

endmodule
`default_nettype wire
